lsu_controller: RTL

- Sequences every load/store between the execute stage and the data-memory port.
- Accepts one request at a time. Checks alignment, then drives the word-aligned memory request with byte-lane write enables and replicated store data.
- Waits for the memory handshake, with a timeout.
- Returns load data that is lane-extracted and sign- or zero-extended, plus an error code, in a single-cycle response.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/riscv_pkg.sv | 17 +
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_controller.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Types and helpers for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } lsu_err_e;

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  // Unknown funct3 codes are never flagged; they complete as no-ops.
  function automatic logic is_misaligned(input logic       store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (store) begin
      case (funct3)
        riscv_pkg::FUNCT3_SH: mis = lane[0];
        riscv_pkg::FUNCT3_SW: mis = (lane != 2'b00);
        default:              mis = 1'b0;
      endcase
    end else begin
      case (funct3)
        riscv_pkg::FUNCT3_LH,
        riscv_pkg::FUNCT3_LHU: mis = lane[0];
        riscv_pkg::FUNCT3_LW:  mis = (lane != 2'b00);
        default:               mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings used by the load/store path.
// FUNCT3 values select the access size and extension of loads and stores.
package riscv_pkg;

  // Store sizes
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Load sizes and extension
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the memory
// word and sign- or zero-extends it to 32 bits.
//   funct3 : load size/extension code
//   addr   : byte offset within the word
//   rdata  : raw memory word
//   data   : extended load result (0 for unknown funct3)
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      FUNCT3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: data = {24'h0, byte_sel};
      FUNCT3_LH:  data = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LHU: data = {16'h0, half_sel};
      FUNCT3_LW:  data = rdata;
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer between the execute stage and the data-memory port.
// One access at a time: alignment check, word-aligned memory request with
// byte enables, handshake with timeout, single-cycle response.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : access from execute (req_ready high only in IDLE)
//   mem_*               : data-memory request/grant/completion port
//   rsp_valid/rdata/err : one-cycle response (err 00 ok, 01 misaligned, 10 timeout)
//   busy                : controller is not idle
//
// state | meaning
// IDLE  | waiting for an access, req_ready high
// REQ   | mem_req driven, waiting for mem_gnt
// WAIT  | granted, waiting for mem_rvalid
// RESP  | rsp_valid pulse, back to IDLE next cycle
module lsu_controller
  import riscv_pkg::*;
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  lsu_state_e       state, state_nxt;
  lsu_err_e         err_nxt;
  logic             store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, misalign, tmo;
  logic [31:0]      st_wdata, ld_data;
  logic [3:0]       st_be;

  assign accept    = (state == IDLE) && req_valid;
  assign misalign  = is_misaligned(req_store, req_funct3, req_addr[1:0]);
  // Counter keeps running through WAIT, so a grant on the last REQ cycle can
  // leave it past the terminal value; compare with >= to still expire.
  assign tmo       = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_req   = (state == REQ);

  always_comb begin
    st_wdata = req_wdata;
    st_be    = 4'b0000;
    case (req_funct3)
      FUNCT3_SB: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_be    = 4'b0001 << req_addr[1:0];
      end
      FUNCT3_SH: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      FUNCT3_SW: st_be = 4'b1111;
      default:   st_be = 4'b0000;
    endcase
  end

  lsu_load_align u_align (
    .funct3 (funct3_q),
    .addr   (lane_q),
    .rdata  (mem_rdata),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The exiting event is tested before the timeout so it wins a tie.
  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_NONE;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            state_nxt = RESP;
            err_nxt   = ERR_MISALIGN;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt = WAIT;
        end else if (tmo) begin
          state_nxt = RESP;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt = RESP;
        end else if (tmo) begin
          state_nxt = RESP;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q   <= 1'b0;
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_NONE;
    end else begin
      if (accept) begin
        store_q   <= req_store;
        funct3_q  <= req_funct3;
        lane_q    <= req_addr[1:0];
        cnt       <= '0;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= req_store ? st_wdata : 32'h0;
        mem_be    <= (req_store && !misalign) ? st_be : 4'b0000;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      rsp_valid <= (state_nxt == RESP);
      rsp_err   <= (state_nxt == RESP) ? err_nxt : ERR_NONE;
      rsp_rdata <= (state == WAIT && mem_rvalid && !store_q) ? ld_data : 32'h0;
    end
  end

endmodule
